// File: rtl/uriscv_mul_div.sv
// RV32M multiply/divide unit: single-cycle-issue multiply, 32-step restoring divider.
// Define URISCV_MUL_2STAGE_EN to add a register stage after the multiplier.
module uriscv_mul_div (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        inst_mul_i,
   input  logic        inst_mulh_i,
   input  logic        inst_mulhsu_i,
   input  logic        inst_mulhu_i,
   input  logic        inst_div_i,
   input  logic        inst_divu_i,
   input  logic        inst_rem_i,
   input  logic        inst_remu_i,
   input  logic [31:0] operand_ra_i,
   input  logic [31:0] operand_rb_i,
   output logic        stall_o,
   output logic        ready_o,
   output logic [31:0] result_o
);

   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   op_e                op_sel;
   logic               any_op;
   logic               accept;
   logic               signed_div;
   logic signed [32:0] mul_a;
   logic signed [32:0] mul_b;
   logic signed [65:0] product;
   logic [31:0]        mul_result;
   logic [31:0]        abs_a;
   logic [31:0]        abs_b;

   logic               div_busy;
   logic [4:0]         div_count;
   logic [31:0]        div_quot;
   logic [31:0]        div_rem;
   logic [31:0]        div_divisor;
   logic               div_is_rem;
   logic               div_neg_q;
   logic               div_neg_r;
   logic [32:0]        rem_shift;
   logic [32:0]        diff;
   logic               q_bit;
   logic [31:0]        rem_next;
   logic [31:0]        quot_next;
   logic [31:0]        div_result;

`ifdef URISCV_MUL_2STAGE_EN
   logic               mul_pend;
   logic [31:0]        mul_res_q;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      op_sel = OP_MUL;
      any_op = 1'b1;
      if (inst_mul_i)         op_sel = OP_MUL;
      else if (inst_mulh_i)   op_sel = OP_MULH;
      else if (inst_mulhsu_i) op_sel = OP_MULHSU;
      else if (inst_mulhu_i)  op_sel = OP_MULHU;
      else if (inst_div_i)    op_sel = OP_DIV;
      else if (inst_divu_i)   op_sel = OP_DIVU;
      else if (inst_rem_i)    op_sel = OP_REM;
      else if (inst_remu_i)   op_sel = OP_REMU;
      else                    any_op = 1'b0;
   end

   assign accept = valid_i & any_op & ~stall_o;

   // 33x33 signed product covers all four signedness combinations.
   assign mul_a      = {((op_sel == OP_MULH) || (op_sel == OP_MULHSU)) & operand_ra_i[31], operand_ra_i};
   assign mul_b      = {(op_sel == OP_MULH) & operand_rb_i[31], operand_rb_i};
   assign product    = mul_a * mul_b;
   assign mul_result = (op_sel == OP_MUL) ? product[31:0] : product[63:32];

   assign signed_div = (op_sel == OP_DIV) || (op_sel == OP_REM);
   assign abs_a      = (signed_div && operand_ra_i[31]) ? -operand_ra_i : operand_ra_i;
   assign abs_b      = (signed_div && operand_rb_i[31]) ? -operand_rb_i : operand_rb_i;

   // One restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
   assign rem_shift  = {div_rem, div_quot[31]};
   assign diff       = rem_shift - {1'b0, div_divisor};
   assign q_bit      = ~diff[32];
   assign rem_next   = q_bit ? diff[31:0] : rem_shift[31:0];
   assign quot_next  = {div_quot[30:0], q_bit};
   assign div_result = div_is_rem ? (div_neg_r ? -rem_next : rem_next)
                                  : (div_neg_q ? -quot_next : quot_next);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_o     <= 1'b0;
         ready_o     <= 1'b0;
         result_o    <= '0;
         div_busy    <= 1'b0;
         div_count   <= '0;
         div_quot    <= '0;
         div_rem     <= '0;
         div_divisor <= '0;
         div_is_rem  <= 1'b0;
         div_neg_q   <= 1'b0;
         div_neg_r   <= 1'b0;
`ifdef URISCV_MUL_2STAGE_EN
         mul_pend    <= 1'b0;
         mul_res_q   <= '0;
`endif
      end else begin
         ready_o <= 1'b0;
`ifdef URISCV_MUL_2STAGE_EN
         if (mul_pend) begin
            result_o <= mul_res_q;
            ready_o  <= 1'b1;
            stall_o  <= 1'b0;
            mul_pend <= 1'b0;
         end
`endif
         if (div_busy) begin
            div_quot  <= quot_next;
            div_rem   <= rem_next;
            div_count <= div_count + 5'd1;
            if (div_count == 5'd31) begin
               div_busy <= 1'b0;
               stall_o  <= 1'b0;
               ready_o  <= 1'b1;
               result_o <= div_result;
            end
         end else if (accept) begin
            if (op_sel[2]) begin
               div_busy    <= 1'b1;
               stall_o     <= 1'b1;
               div_count   <= '0;
               div_quot    <= abs_a;
               div_rem     <= '0;
               div_divisor <= abs_b;
               div_is_rem  <= (op_sel == OP_REM) || (op_sel == OP_REMU);
               div_neg_q   <= signed_div && (operand_ra_i[31] ^ operand_rb_i[31]) && (operand_rb_i != '0);
               div_neg_r   <= signed_div && operand_ra_i[31];
            end else begin
`ifdef URISCV_MUL_2STAGE_EN
               mul_res_q <= mul_result;
               mul_pend  <= 1'b1;
               stall_o   <= 1'b1;
`else
               result_o  <= mul_result;
               ready_o   <= 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_uriscv_mul_div.sv
// Directed self-checking bench for uriscv_mul_div (multiply, divide, corner cases, stall and reset).
module tb_uriscv_mul_div;

   localparam logic [7:0] M_MUL    = 8'b0000_0001;
   localparam logic [7:0] M_MULH   = 8'b0000_0010;
   localparam logic [7:0] M_MULHSU = 8'b0000_0100;
   localparam logic [7:0] M_MULHU  = 8'b0000_1000;
   localparam logic [7:0] M_DIV    = 8'b0001_0000;
   localparam logic [7:0] M_DIVU   = 8'b0010_0000;
   localparam logic [7:0] M_REM    = 8'b0100_0000;
   localparam logic [7:0] M_REMU   = 8'b1000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [7:0]  ops;
   logic [31:0] ra;
   logic [31:0] rb;
   logic        stall;
   logic        ready;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   uriscv_mul_div dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid),
      .inst_mul_i    (ops[0]),
      .inst_mulh_i   (ops[1]),
      .inst_mulhsu_i (ops[2]),
      .inst_mulhu_i  (ops[3]),
      .inst_div_i    (ops[4]),
      .inst_divu_i   (ops[5]),
      .inst_rem_i    (ops[6]),
      .inst_remu_i   (ops[7]),
      .operand_ra_i  (ra),
      .operand_rb_i  (rb),
      .stall_o       (stall),
      .ready_o       (ready),
      .result_o      (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents one op for a single edge; returns #1 after that edge (cycle T+1).
   task automatic issue(input logic [7:0] opv, input logic [31:0] a, input logic [31:0] b);
      ops   = opv;
      ra    = a;
      rb    = b;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      ops   = '0;
   endtask

   task automatic run_mul(input string tag, input logic [7:0] opv,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      issue(opv, a, b);
`ifdef URISCV_MUL_2STAGE_EN
      check({tag, " stall T+1"}, 32'(stall), 32'd1);
      check({tag, " ready T+1"}, 32'(ready), 32'd0);
      @(posedge clk);
      #1;
`endif
      check({tag, " ready"}, 32'(ready), 32'd1);
      check({tag, " stall"}, 32'(stall), 32'd0);
      check({tag, " result"}, result, exp);
      @(posedge clk);
      #1;
      check({tag, " single pulse"}, 32'(ready), 32'd0);
   endtask

   task automatic run_div(input string tag, input logic [7:0] opv,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int bad;
      bad = 0;
      issue(opv, a, b);
      for (int k = 1; k <= 32; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (stall !== 1'b1 || ready !== 1'b0) bad++;
      end
      check({tag, " stall window"}, bad, 0);
      @(posedge clk);
      #1;
      check({tag, " ready"}, 32'(ready), 32'd1);
      check({tag, " stall clear"}, 32'(stall), 32'd0);
      check({tag, " result"}, result, exp);
      @(posedge clk);
      #1;
      check({tag, " single pulse"}, 32'(ready), 32'd0);
   endtask

   initial begin
      int bad;
      rst   = 1'b1;
      valid = 1'b0;
      ops   = '0;
      ra    = '0;
      rb    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset stall", 32'(stall), 32'd0);
      check("reset ready", 32'(ready), 32'd0);
      check("reset result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_mul("mulhsu", M_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
      run_mul("mul", M_MUL, 32'd7, 32'd6, 32'h0000_002A);
      run_mul("mulh", M_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_mul("mulhu", M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_mul("prio mul>div", M_MUL | M_DIV, 32'd7, 32'd6, 32'h0000_002A);
      run_mul("prio mulh>mulhu", M_MULH | M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

      run_div("div -7/2", M_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_div("rem -7%2", M_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_div("divu 100/7", M_DIVU, 32'd100, 32'd7, 32'd14);
      run_div("remu 100%7", M_REMU, 32'd100, 32'd7, 32'd2);
      run_div("div by 0", M_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
      run_div("divu by 0", M_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
      run_div("rem by 0", M_REM, 32'h1234_5678, 32'd0, 32'h1234_5678);
      run_div("remu by 0", M_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
      run_div("div ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_div("rem ovf", M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      run_div("rem neg/neg", M_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

      // A multiply offered mid-divide must be dropped and must not disturb the divide.
      bad = 0;
      issue(M_DIVU, 32'd100, 32'd7);
      for (int k = 1; k <= 32; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (k == 5) begin
            ops   = M_MUL;
            ra    = 32'd2;
            rb    = 32'd3;
            valid = 1'b1;
         end else if (k == 6) begin
            ops   = '0;
            valid = 1'b0;
         end
         if (stall !== 1'b1 || ready !== 1'b0) bad++;
      end
      check("ignore-in-stall window", bad, 0);
      @(posedge clk);
      #1;
      check("ignore-in-stall ready", 32'(ready), 32'd1);
      check("ignore-in-stall result", result, 32'd14);
      @(posedge clk);
      #1;
      check("ignore-in-stall no extra ready", 32'(ready), 32'd0);
      check("result holds", result, 32'd14);

      // valid with no op bit is not an accept.
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      check("no-op ready", 32'(ready), 32'd0);
      check("no-op stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("no-op ready late", 32'(ready), 32'd0);
      check("no-op result", result, 32'd14);

      // Reset in the middle of a divide aborts it.
      issue(M_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid reset stall", 32'(stall), 32'd0);
      check("mid reset ready", 32'(ready), 32'd0);
      check("mid reset result", result, 32'd0);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b0 || stall !== 1'b0) bad++;
      end
      check("no ready after abort", bad, 0);

      run_mul("mul after reset", M_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
